// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter
// Interrupt front end for the 8227 core. It synchronises NMI and NUM_IRQ
// request lines and keeps a pending bit for each source. It arbitrates
// reset > NMI > lowest-index eligible IRQ and presents one registered request,
// with its vector, to the instruction loader.
//
// Ports:
//   clk            system clock, rising edge
//   nrst           asynchronous reset, active-high
//   enableFFs      core advance enable; outputs hold while 0
//   nmi_in         asynchronous NMI, rising-edge triggered
//   irq_in         asynchronous maskable request lines, active-high
//   irq_edge_mode  per-channel mode: 1 = edge, 0 = level
//   mask_we        mask register write strobe
//   mask_wdata     new mask value (1 = channel masked)
//   psr_i_flag     PSR I flag; 1 blocks every IRQ channel
//   take           loader accepts the presented request
//   int_valid      a request is presented
//   int_kind       00 none, 01 reset, 10 NMI, 11 IRQ
//   int_channel    granted IRQ channel (0 unless kind = IRQ)
//   vector_addr    vector of the presented request
//   reset_running  reset sequence pending and not yet taken
//   irq_pending    raw pending bits, before mask and I flag
module interrupt_arbiter #(
  parameter int unsigned           NUM_IRQ         = 4,
  parameter int unsigned           ADDR_WIDTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR    = 16'hFFFC,
  parameter logic [ADDR_WIDTH-1:0] NMI_VECTOR      = 16'hFFFA,
  parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR_BASE = 16'hFFE0
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  enableFFs,
  input  logic                  nmi_in,
  input  logic [NUM_IRQ-1:0]    irq_in,
  input  logic [NUM_IRQ-1:0]    irq_edge_mode,
  input  logic                  mask_we,
  input  logic [NUM_IRQ-1:0]    mask_wdata,
  input  logic                  psr_i_flag,
  input  logic                  take,
  output logic                  int_valid,
  output logic [1:0]            int_kind,
  output logic [3:0]            int_channel,
  output logic [ADDR_WIDTH-1:0] vector_addr,
  output logic                  reset_running,
  output logic [NUM_IRQ-1:0]    irq_pending
);

  localparam logic [1:0] KIND_NONE  = 2'b00;
  localparam logic [1:0] KIND_RESET = 2'b01;
  localparam logic [1:0] KIND_NMI   = 2'b10;
  localparam logic [1:0] KIND_IRQ   = 2'b11;

  logic                  nmi_s1, nmi_s2, nmi_h, nmi_pend, rst_pend;
  logic [NUM_IRQ-1:0]    irq_s1, irq_s2, irq_h, mask;
  logic                  take_ok, rst_clr, nmi_clr, nmi_rise;
  logic [NUM_IRQ-1:0]    irq_clr, irq_rise, irq_elig;
  logic                  nxt_valid;
  logic [1:0]            nxt_kind;
  logic [3:0]            nxt_ch;
  logic [ADDR_WIDTH-1:0] nxt_vec;

  // A take only counts against the request currently on the outputs.
  assign take_ok  = take & int_valid & enableFFs;
  assign rst_clr  = take_ok && (int_kind == KIND_RESET);
  assign nmi_clr  = take_ok && (int_kind == KIND_NMI);
  assign nmi_rise = nmi_s2 & ~nmi_h;
  assign irq_rise = irq_s2 & ~irq_h;

  // Level-mode channels ignore take, so only edge-mode bits can be cleared.
  always_comb begin
    irq_clr = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      irq_clr[i] = take_ok && (int_kind == KIND_IRQ) && (int_channel == 4'(i))
                   && irq_edge_mode[i];
    end
  end

  assign irq_elig      = irq_pending & ~mask & ~{NUM_IRQ{psr_i_flag}} & ~irq_clr;
  assign reset_running = rst_pend;

  // Synchronisers, pending state and mask run every cycle, stalled or not.
  // The set term is ORed after the clear term, so a new edge wins over a take.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      nmi_s1      <= 1'b0;
      nmi_s2      <= 1'b0;
      nmi_h       <= 1'b0;
      nmi_pend    <= 1'b0;
      rst_pend    <= 1'b1;
      irq_s1      <= '0;
      irq_s2      <= '0;
      irq_h       <= '0;
      irq_pending <= '0;
      mask        <= '1;
    end else begin
      nmi_s1      <= nmi_in;
      nmi_s2      <= nmi_s1;
      nmi_h       <= nmi_s2;
      nmi_pend    <= nmi_rise | (nmi_pend & ~nmi_clr);
      rst_pend    <= rst_pend & ~rst_clr;
      irq_s1      <= irq_in;
      irq_s2      <= irq_s1;
      irq_h       <= irq_s2;
      irq_pending <= (irq_edge_mode & (irq_rise | (irq_pending & ~irq_clr)))
                   | (~irq_edge_mode & irq_s2);
      if (mask_we) begin
        mask <= mask_wdata;
      end
    end
  end

  // Arbitration uses the pending state with the source being taken removed.
  always_comb begin
    nxt_valid = 1'b0;
    nxt_kind  = KIND_NONE;
    nxt_ch    = '0;
    nxt_vec   = '0;
    if (rst_pend && !rst_clr) begin
      nxt_valid = 1'b1;
      nxt_kind  = KIND_RESET;
      nxt_vec   = RESET_VECTOR;
    end else if (nmi_pend && !nmi_clr) begin
      nxt_valid = 1'b1;
      nxt_kind  = KIND_NMI;
      nxt_vec   = NMI_VECTOR;
    end else begin
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
        if (irq_elig[i] && !nxt_valid) begin
          nxt_valid = 1'b1;
          nxt_kind  = KIND_IRQ;
          nxt_ch    = 4'(i);
          nxt_vec   = IRQ_VECTOR_BASE + ADDR_WIDTH'(2 * i);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      int_valid   <= 1'b0;
      int_kind    <= KIND_NONE;
      int_channel <= '0;
      vector_addr <= '0;
    end else if (enableFFs) begin
      int_valid   <= nxt_valid;
      int_kind    <= nxt_kind;
      int_channel <= nxt_ch;
      vector_addr <= nxt_vec;
    end
  end

endmodule

// File: tb/tb_interrupt_arbiter.sv
module tb_interrupt_arbiter;

  logic        clk = 1'b0;
  logic        nrst, enableFFs, nmi_in, mask_we, psr_i_flag, take;
  logic [3:0]  irq_in, irq_edge_mode, mask_wdata;
  logic        int_valid, reset_running;
  logic [1:0]  int_kind;
  logic [3:0]  int_channel, irq_pending;
  logic [15:0] vector_addr;

  typedef struct {
    string       name;
    logic        v;
    logic [1:0]  k;
    logic [3:0]  c;
    logic [15:0] a;
    logic        rr;
    logic [3:0]  p;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  interrupt_arbiter dut (
    .clk(clk), .nrst(nrst), .enableFFs(enableFFs), .nmi_in(nmi_in),
    .irq_in(irq_in), .irq_edge_mode(irq_edge_mode), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .psr_i_flag(psr_i_flag), .take(take),
    .int_valid(int_valid), .int_kind(int_kind), .int_channel(int_channel),
    .vector_addr(vector_addr), .reset_running(reset_running),
    .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string n, input logic v, input logic [1:0] k,
                      input logic [3:0] c, input logic [15:0] a,
                      input logic rr, input logic [3:0] p);
    exp_t x;
    x.name = n; x.v = v; x.k = k; x.c = c; x.a = a; x.rr = rr; x.p = p;
    sb.push_back(x);
  endtask

  function automatic string show(input logic v, input logic [1:0] k,
                                 input logic [3:0] c, input logic [15:0] a,
                                 input logic rr, input logic [3:0] p);
    return $sformatf("v=%b kind=%b ch=%0d vec=%h rr=%b pend=%b", v, k, c, a, rr, p);
  endfunction

  task automatic write_mask(input logic [3:0] m);
    mask_we = 1'b1; mask_wdata = m;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    #1 nrst = 1'b1;
    #2;
    push("reset_state", 0, 2'b00, 0, 16'h0000, 1, 4'b0000);
    e = sb.pop_front(); checks++;
    if ({int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending}
        !== {e.v, e.k, e.c, e.a, e.rr, e.p}) begin
      errors++;
      $display("FAIL %s: got %s expected %s", e.name,
        show(int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending),
        show(e.v, e.k, e.c, e.a, e.rr, e.p));
    end
    tick(2);
    nrst = 1'b0;
    push("reset_presented", 1, 2'b01, 0, 16'hFFFC, 1, 4'b0000);
    tick();
    e = sb.pop_front(); checks++;
    if ({int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending}
        !== {e.v, e.k, e.c, e.a, e.rr, e.p}) begin
      errors++;
      $display("FAIL %s: got %s expected %s", e.name,
        show(int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending),
        show(e.v, e.k, e.c, e.a, e.rr, e.p));
    end
    take = 1'b1;
    push("reset_taken", 0, 2'b00, 0, 16'h0000, 0, 4'b0000);
    tick();
    take = 1'b0;
    e = sb.pop_front(); checks++;
    if ({int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending}
        !== {e.v, e.k, e.c, e.a, e.rr, e.p}) begin
      errors++;
      $display("FAIL %s: got %s expected %s", e.name,
        show(int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending),
        show(e.v, e.k, e.c, e.a, e.rr, e.p));
    end
  endtask

  task automatic test_nmi_vs_irq;
    write_mask(4'b0000);
    irq_in = 4'b0100; nmi_in = 1'b1;
    push("latency_pending_only", 0, 2'b00, 0, 16'h0000, 0, 4'b0100);
    push("nmi_first", 1, 2'b10, 0, 16'hFFFA, 0, 4'b0100);
    push("irq2_after_nmi", 1, 2'b11, 2, 16'hFFE4, 0, 4'b0100);
    push("irq2_taken", 0, 2'b00, 0, 16'h0000, 0, 4'b0000);
    tick(3);
    e = sb.pop_front(); checks++;
    if ({int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending}
        !== {e.v, e.k, e.c, e.a, e.rr, e.p}) begin
      errors++;
      $display("FAIL %s: got %s expected %s", e.name,
        show(int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending),
        show(e.v, e.k, e.c, e.a, e.rr, e.p));
    end
    for (int n = 0; n < 3; n++) begin
      tick();
      take = 1'b0;
      e = sb.pop_front(); checks++;
      if ({int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending}
          !== {e.v, e.k, e.c, e.a, e.rr, e.p}) begin
        errors++;
        $display("FAIL %s: got %s expected %s", e.name,
          show(int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending),
          show(e.v, e.k, e.c, e.a, e.rr, e.p));
      end
      take = 1'b1;
    end
    take = 1'b0;
    irq_in = 4'b0000; nmi_in = 1'b0;
    tick(3);
  endtask

  task automatic test_priority_mask;
    irq_edge_mode = 4'b1100;
    write_mask(4'b0001);
    irq_in = 4'b0011;
    push("masked_ch0_grants_ch1", 1, 2'b11, 1, 16'hFFE2, 0, 4'b0011);
    tick(4);
    e = sb.pop_front(); checks++;
    if ({int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending}
        !== {e.v, e.k, e.c, e.a, e.rr, e.p}) begin
      errors++;
      $display("FAIL %s: got %s expected %s", e.name,
        show(int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending),
        show(e.v, e.k, e.c, e.a, e.rr, e.p));
    end
    psr_i_flag = 1'b1;
    push("i_flag_blocks", 0, 2'b00, 0, 16'h0000, 0, 4'b0011);
    tick();
    e = sb.pop_front(); checks++;
    if ({int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending}
        !== {e.v, e.k, e.c, e.a, e.rr, e.p}) begin
      errors++;
      $display("FAIL %s: got %s expected %s", e.name,
        show(int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending),
        show(e.v, e.k, e.c, e.a, e.rr, e.p));
    end
    psr_i_flag = 1'b0; irq_in = 4'b0000;
    push("level_released", 0, 2'b00, 0, 16'h0000, 0, 4'b0000);
    tick(4);
    e = sb.pop_front(); checks++;
    if ({int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending}
        !== {e.v, e.k, e.c, e.a, e.rr, e.p}) begin
      errors++;
      $display("FAIL %s: got %s expected %s", e.name,
        show(int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending),
        show(e.v, e.k, e.c, e.a, e.rr, e.p));
    end
    irq_edge_mode = 4'b1101;
    write_mask(4'b0000);
  endtask

  task automatic test_edge_level;
    irq_in = 4'b0011;
    tick();
    irq_in = 4'b0000;
    push("both_pending", 0, 2'b00, 0, 16'h0000, 0, 4'b0011);
    push("level_dropped_edge_held", 1, 2'b11, 0, 16'hFFE0, 0, 4'b0001);
    push("edge_held_until_take", 1, 2'b11, 0, 16'hFFE0, 0, 4'b0001);
    push("edge_cleared_by_take", 0, 2'b00, 0, 16'h0000, 0, 4'b0000);
    for (int n = 0; n < 4; n++) begin
      if (n == 3) take = 1'b1;
      tick((n == 0) ? 2 : (n == 2) ? 3 : 1);
      take = 1'b0;
      e = sb.pop_front(); checks++;
      if ({int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending}
          !== {e.v, e.k, e.c, e.a, e.rr, e.p}) begin
        errors++;
        $display("FAIL %s: got %s expected %s", e.name,
          show(int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending),
          show(e.v, e.k, e.c, e.a, e.rr, e.p));
      end
    end
  endtask

  task automatic test_stall;
    enableFFs = 1'b0;
    nmi_in = 1'b1;
    tick();
    nmi_in = 1'b0;
    push("stall_frozen", 0, 2'b00, 0, 16'h0000, 0, 4'b0000);
    push("nmi_after_stall", 1, 2'b10, 0, 16'hFFFA, 0, 4'b0000);
    push("take_ignored_in_stall", 1, 2'b10, 0, 16'hFFFA, 0, 4'b0000);
    push("nmi_taken", 0, 2'b00, 0, 16'h0000, 0, 4'b0000);
    tick(4);
    for (int n = 0; n < 4; n++) begin
      e = sb.pop_front(); checks++;
      if ({int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending}
          !== {e.v, e.k, e.c, e.a, e.rr, e.p}) begin
        errors++;
        $display("FAIL %s: got %s expected %s", e.name,
          show(int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending),
          show(e.v, e.k, e.c, e.a, e.rr, e.p));
      end
      enableFFs = (n != 1);
      take      = (n >= 1);
      if (n < 3) tick();
    end
    take = 1'b0; enableFFs = 1'b1;
  endtask

  task automatic test_set_beats_clear;
    irq_in = 4'b1000;
    push("ch3_presented", 1, 2'b11, 3, 16'hFFE6, 0, 4'b1000);
    tick(4);
    e = sb.pop_front(); checks++;
    if ({int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending}
        !== {e.v, e.k, e.c, e.a, e.rr, e.p}) begin
      errors++;
      $display("FAIL %s: got %s expected %s", e.name,
        show(int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending),
        show(e.v, e.k, e.c, e.a, e.rr, e.p));
    end
    irq_in = 4'b0000;
    tick(3);
    irq_in = 4'b1000;
    tick(2);
    take = 1'b1;
    push("set_beats_clear", 0, 2'b00, 0, 16'h0000, 0, 4'b1000);
    push("ch3_represented", 1, 2'b11, 3, 16'hFFE6, 0, 4'b1000);
    push("ch3_final_take", 0, 2'b00, 0, 16'h0000, 0, 4'b0000);
    for (int n = 0; n < 3; n++) begin
      tick();
      take = (n == 1);
      e = sb.pop_front(); checks++;
      if ({int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending}
          !== {e.v, e.k, e.c, e.a, e.rr, e.p}) begin
        errors++;
        $display("FAIL %s: got %s expected %s", e.name,
          show(int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending),
          show(e.v, e.k, e.c, e.a, e.rr, e.p));
      end
    end
    take = 1'b0;
    irq_in = 4'b0000;
    tick(3);
  endtask

  task automatic test_reset_midway;
    nmi_in = 1'b1;
    irq_in = 4'b0001;
    push("nmi_before_reset", 1, 2'b10, 0, 16'hFFFA, 0, 4'b0001);
    tick(4);
    e = sb.pop_front(); checks++;
    if ({int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending}
        !== {e.v, e.k, e.c, e.a, e.rr, e.p}) begin
      errors++;
      $display("FAIL %s: got %s expected %s", e.name,
        show(int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending),
        show(e.v, e.k, e.c, e.a, e.rr, e.p));
    end
    nrst = 1'b1; nmi_in = 1'b0; irq_in = 4'b0000;
    #1;
    push("async_reset_mid", 0, 2'b00, 0, 16'h0000, 1, 4'b0000);
    push("reset_again", 1, 2'b01, 0, 16'hFFFC, 1, 4'b0000);
    push("pending_discarded", 0, 2'b00, 0, 16'h0000, 0, 4'b0000);
    for (int n = 0; n < 3; n++) begin
      e = sb.pop_front(); checks++;
      if ({int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending}
          !== {e.v, e.k, e.c, e.a, e.rr, e.p}) begin
        errors++;
        $display("FAIL %s: got %s expected %s", e.name,
          show(int_valid, int_kind, int_channel, vector_addr, reset_running, irq_pending),
          show(e.v, e.k, e.c, e.a, e.rr, e.p));
      end
      if (n == 0) begin
        tick();
        nrst = 1'b0;
      end
      take = (n == 1);
      if (n < 2) tick();
    end
    take = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; enableFFs = 1'b1; nmi_in = 1'b0; mask_we = 1'b0;
    psr_i_flag = 1'b0; take = 1'b0; irq_in = '0; mask_wdata = '0;
    irq_edge_mode = 4'b1101;
    test_reset();
    test_nmi_vs_irq();
    test_priority_mask();
    test_edge_level();
    test_stall();
    test_set_beats_clear();
    test_reset_midway();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_arbiter.md
# interrupt_arbiter

Parametrised interrupt front end for the 8227 core: synchronises an NMI line and NUM_IRQ maskable request lines, tracks pending state per source (edge or level mode), arbitrates reset > NMI > IRQ by fixed priority and presents one registered request with its vector to the instruction loader. The loader acknowledges with `take` at an instruction boundary. It generalises the single-IRQ/NMI/reset handling in the current top level with multiple channels, per-channel masking and per-channel vectors.

## Interface
- NUM_IRQ, 4, number of maskable channels (1..16)
- ADDR_WIDTH, 16, vector width
- RESET_VECTOR, 16'hFFFC, reset vector address
- NMI_VECTOR, 16'hFFFA, NMI vector address
- IRQ_VECTOR_BASE, 16'hFFE0, channel i vector = IRQ_VECTOR_BASE + 2*i (mod 2^ADDR_WIDTH)
- clk  in  1  single system clock, all flops on rising edge
- nrst  in  1  asynchronous reset, active-high (asserted = 1); name kept per codebase
- enableFFs  in  1  core advance enable; 0 = stall
- nmi_in  in  1  asynchronous NMI, rising-edge triggered
- irq_in  in  NUM_IRQ  asynchronous request lines, active-high
- irq_edge_mode  in  NUM_IRQ  static config; 1 = edge, 0 = level
- mask_we  in  1  mask register write strobe
- mask_wdata  in  NUM_IRQ  new mask, 1 = channel masked
- psr_i_flag  in  1  PSR I flag; 1 blocks all IRQ channels
- take  in  1  core accepts the presented request this cycle
- int_valid  out  1  a request is presented
- int_kind  out  2  00 none, 01 RESET, 10 NMI, 11 IRQ
- int_channel  out  4  granted IRQ channel (0 unless kind = IRQ)
- vector_addr  out  ADDR_WIDTH  vector of presented request
- reset_running  out  1  reset sequence pending, not yet taken
- irq_pending  out  NUM_IRQ  raw pending bits (before mask / I flag)

## Operation
- Sync: 2-flop synchronisers on nmi_in and each irq_in, plus one history flop per line for edge detection; these and the pending registers run every cycle regardless of enableFFs, so no edge is lost during stall.
- NMI pending: set on synchronised rising edge; cleared when a taken request had kind = NMI. Not maskable.
- IRQ pending[i], edge mode: set on synchronised rising edge, cleared when channel i taken. Level mode: equals synchronised level; take has no effect.
- Set beats clear: edge arriving in the same cycle its source is taken leaves pending = 1.
- Reset pending: set by nrst; cleared when kind = RESET taken. reset_running = reset pending.
- Mask register: NUM_IRQ bits, reset all 1s (all masked); loads mask_wdata on mask_we (independent of enableFFs).
- Eligible IRQ = pending & ~mask & ~{NUM_IRQ{psr_i_flag}}.
- Arbitration: reset > NMI > lowest-index eligible IRQ. None -> int_valid 0, kind 00, channel 0, vector 0.
- Outputs registered, updated only on cycles with enableFFs = 1; they hold otherwise.
- take honoured only when int_valid = 1 and enableFFs = 1; otherwise ignored. Grant cleared is the one currently presented (registered), not a fresh arbitration.
- In a take cycle, next-cycle outputs are arbitrated with the taken source removed; next request may appear immediately.
- mask_we concurrent with take: take clears presented source; new mask applies from next arbitration.

## Timing
- Reset values: int_valid 0, int_kind 00, int_channel 0, vector_addr 0, reset_running 1, irq_pending 0, mask all 1s, synchronisers 0, NMI pending 0.
- First enabled edge after nrst release: int_valid 1, kind RESET, vector RESET_VECTOR.
- Input latency: input high at rising edge k -> sync stage 2 at k+1 -> pending at k+2 -> int_valid at k+3 (enableFFs = 1).
- Mask/I-flag change affects int_valid at the next enabled edge (1 cycle).
- take at edge t -> source cleared and outputs re-arbitrated at edge t.
- nrst mid-sequence: all state returns to reset values immediately; pending sources discarded.

## Test plan
- Reset: release nrst, enableFFs 1 -> int_valid 1, kind 01, vector 16'hFFFC, reset_running 1; take 1 cycle -> reset_running 0, int_valid 0.
- NMI vs IRQ: mask 0, irq_in[2] and nmi_in rise in same cycle -> after 3 cycles kind 10, vector 16'hFFFA; take -> next cycle kind 11, channel 2, vector 16'hFFE4.
- Priority/mask: mask = 4'b0001, irq_in = 4'b0011 level -> channel 1, vector 16'hFFE2; psr_i_flag 1 -> int_valid 0 next cycle.
- Edge vs level: ch0 edge, ch1 level, both pulse 1 cycle high then low -> ch0 stays pending until take, ch1 pending drops 3 cycles after fall.
- Stall: enableFFs 0, pulse nmi_in 1 cycle -> outputs frozen; enableFFs 1 -> kind 10 at next edge.
- Set-beats-clear: edge-mode ch3 presented, new rising edge synchronised in take cycle -> irq_pending[3] remains 1, ch3 re-presented next cycle.
